// File: rtl/tone_sample_generator.sv
// Square-wave tone source with a linear attack/release envelope, handing one
// signed 16-bit sample at a time to a ready/valid consumer.
module tone_sample_generator #(
  parameter logic [15:0] AMP_STEP = 16'd64,
  parameter logic [15:0] AMP_MAX  = 16'd8192
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         half_period,
  input  logic               sample_ready,
  output logic               sample_valid,
  output logic signed [15:0] sample_data,
  output logic               note_active
);

  localparam logic [0:0] S_COMPUTE = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  logic [0:0]         r_state;
  logic [7:0]         r_cur_period;
  logic [7:0]         r_phase;
  logic               r_polarity;
  logic [15:0]        r_amp;
  logic signed [15:0] r_sample;

  logic [15:0]        w_amp_nxt;
  logic [7:0]         w_phase_inc;
  logic [7:0]         w_period_nxt;
  logic [7:0]         w_phase_nxt;
  logic               w_polarity_nxt;
  logic signed [15:0] w_sample_nxt;

  function automatic logic [15:0] amp_rise(input logic [15:0] a);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, AMP_STEP};
    if (s > {1'b0, AMP_MAX}) return AMP_MAX;
    return s[15:0];
  endfunction

  function automatic logic [15:0] amp_fall(input logic [15:0] a);
    if (a <= AMP_STEP) return 16'd0;
    return a - AMP_STEP;
  endfunction

  function automatic logic signed [15:0] signed_level(input logic pol, input logic [15:0] a);
    logic signed [15:0] s;
    s = $signed(a);
    return pol ? -s : s;
  endfunction

  always_comb begin
    w_amp_nxt      = (half_period != 8'd0) ? amp_rise(r_amp) : amp_fall(r_amp);
    w_phase_inc    = r_phase + 8'd1;
    w_period_nxt   = r_cur_period;
    w_phase_nxt    = r_phase;
    w_polarity_nxt = r_polarity;
    w_sample_nxt   = (r_cur_period == 8'd0) ? 16'sd0 : signed_level(r_polarity, r_amp);

    if (r_cur_period == 8'd0) begin
      if (half_period != 8'd0) begin
        w_period_nxt   = half_period;
        w_phase_nxt    = 8'd0;
        w_polarity_nxt = 1'b0;
      end
    end else if (w_phase_inc == r_cur_period) begin
      // Period changes are only accepted here, at a half-cycle boundary.
      w_phase_nxt    = 8'd0;
      w_polarity_nxt = ~r_polarity;
      if (half_period != 8'd0) w_period_nxt = half_period;
    end else begin
      w_phase_nxt = w_phase_inc;
    end

    // Release finished: silence the oscillator entirely.
    if ((half_period == 8'd0) && (w_amp_nxt == 16'd0)) begin
      w_period_nxt   = 8'd0;
      w_phase_nxt    = 8'd0;
      w_polarity_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_COMPUTE;
      r_cur_period <= 8'd0;
      r_phase      <= 8'd0;
      r_polarity   <= 1'b0;
      r_amp        <= 16'd0;
      r_sample     <= 16'sd0;
    end else begin
      case (r_state)
        S_COMPUTE: begin
          r_state      <= S_HOLD;
          r_sample     <= w_sample_nxt;
          r_cur_period <= w_period_nxt;
          r_phase      <= w_phase_nxt;
          r_polarity   <= w_polarity_nxt;
          r_amp        <= w_amp_nxt;
        end
        default: begin
          if (sample_ready) r_state <= S_COMPUTE;
        end
      endcase
    end
  end

  assign sample_valid = (r_state == S_HOLD);
  assign sample_data  = r_sample;
  assign note_active  = (r_cur_period != 8'd0);

endmodule

// File: tb/tb_tone_sample_generator.sv
// Directed bench for tone_sample_generator: a sample-level model is checked
// against the DUT every cycle, plus literal expectations for key sequences.
module tb_tone_sample_generator;

  localparam int STEP = 64;
  localparam int AMAX = 8192;

  logic               clk;
  logic               rst;
  logic [7:0]         half_period;
  logic               sample_ready;
  logic               sample_valid;
  logic signed [15:0] sample_data;
  logic               note_active;

  tone_sample_generator #(.AMP_STEP(16'd64), .AMP_MAX(16'd8192)) dut (
    .clk(clk),
    .rst(rst),
    .half_period(half_period),
    .sample_ready(sample_ready),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .note_active(note_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Model: note state kept as "samples left in this half" rather than a phase.
  int m_period = 0, m_left = 0, m_pol = 0, m_amp = 0, m_data = 0;
  bit m_valid = 1'b0;
  int q[$];

  always begin
    int hp;
    @(posedge clk);
    hp = int'(half_period);
    if (rst) begin
      m_period = 0; m_left = 0; m_pol = 0; m_amp = 0; m_data = 0; m_valid = 1'b0;
    end else if (!m_valid) begin
      m_data = (m_period == 0) ? 0 : (m_pol != 0 ? -m_amp : m_amp);
      if (hp != 0) m_amp = (m_amp + STEP > AMAX) ? AMAX : m_amp + STEP;
      else         m_amp = (m_amp < STEP) ? 0 : m_amp - STEP;
      if (m_period == 0) begin
        if (hp != 0) begin
          m_period = hp; m_left = hp; m_pol = 0;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_pol = 1 - m_pol;
          if (hp != 0) m_period = hp;
          m_left = m_period;
        end
      end
      if (hp == 0 && m_amp == 0) begin
        m_period = 0; m_left = 0; m_pol = 0;
      end
      m_valid = 1'b1;
    end else if (sample_ready) begin
      q.push_back(int'(sample_data));
      m_valid = 1'b0;
    end
    #1;
    check("valid", int'(sample_valid), int'(m_valid));
    check("note_active", int'(note_active), (m_period != 0) ? 1 : 0);
    if (m_valid) check("data", int'(sample_data), m_data);
  end

  task automatic wait_xfers(input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (q.size() < n) check("xfer_timeout", q.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  int exp27 [10] = '{0, 64, 128, 192, 256, -320, -384, -448, -512, 576};

  initial begin
    rst = 1'b1;
    half_period = 8'd0;
    sample_ready = 1'b1;

    // Idle: no key pressed, output stays silent.
    do_reset();
    check("reset_valid", int'(sample_valid), 0);
    check("reset_data", int'(sample_data), 0);
    repeat (20) @(negedge clk);
    check("idle_xfer_count_ge9", (q.size() >= 9) ? 1 : 0, 1);
    foreach (q[i]) check("idle_zero", q[i], 0);

    // Attack at half_period 4.
    half_period = 8'd4;
    do_reset();
    wait_xfers(10, 100);
    for (int i = 0; i < 10 && i < q.size(); i++) check("seq27", q[i], exp27[i]);

    // Consumer back-pressure while a sample is held.
    while (!sample_valid) @(negedge clk);
    sample_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("held_valid", int'(sample_valid), 1);
    sample_ready = 1'b1;
    wait_xfers(12, 100);
    if (q.size() >= 12) begin
      check("after_hold_t10", q[10], 640);
      check("after_hold_t11", q[11], 704);
    end

    // Ramp to the ceiling, then release to silence.
    repeat (300) @(negedge clk);
    check("at_max", (q[q.size()-1] < 0) ? -q[q.size()-1] : q[q.size()-1], AMAX);
    half_period = 8'd0;
    repeat (320) @(negedge clk);
    check("release_note_off", int'(note_active), 0);
    check("release_last_zero", q[q.size()-1], 0);

    // Period change mid half-cycle, then reset mid-note.
    half_period = 8'd4;
    do_reset();
    wait_xfers(2, 50);
    half_period = 8'd10;
    wait_xfers(17, 100);
    if (q.size() >= 17) begin
      check("chg_t4", q[4], 256);
      check("chg_t5", q[5], -320);
      check("chg_t14", q[14], -896);
      check("chg_t15", q[15], 960);
      check("chg_t16", q[16], 1024);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", int'(sample_valid), 0);
    check("rst_mid_data", int'(sample_data), 0);
    check("rst_mid_note", int'(note_active), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
